// File: rtl/cpu_pkg.sv
// Shared encodings and types for the pipeline's writeback stage.
package cpu_pkg;

    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;
    localparam logic [2:0] LOAD_LWL = 3'd5;
    localparam logic [2:0] LOAD_LWR = 3'd6;

    localparam logic [1:0] SEL_WB_ALU  = 2'd0;
    localparam logic [1:0] SEL_WB_LOAD = 2'd1;
    localparam logic [1:0] SEL_WB_LINK = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_DM
    } wb_state_e;

    // Fields of a pending load kept while waiting for the memory response
    typedef struct packed {
        logic [4:0] wr;
        logic       reg_wen;
        logic [2:0] load_type;
        logic [1:0] addr;
    } load_ctx_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: the MEM stage is master, wb_stage is slave.
interface wb_stage_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wr;
    logic        mem_reg_wen;
    logic [1:0]  mem_sel_wbdata;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_pc;

    modport master (
        output mem_valid, mem_wr, mem_reg_wen, mem_sel_wbdata,
               mem_load_type, mem_alu_res, mem_pc,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_wr, mem_reg_wen, mem_sel_wbdata,
               mem_load_type, mem_alu_res, mem_pc,
        output mem_ready
    );
endinterface

// File: rtl/load_align.sv
// Aligns and extends a data-memory read word according to the load type and
// the low address bits; also produces the per-byte register write enables.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] dm_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
    output logic [31:0] data,
    output logic [3:0]  be
);

    logic [31:0] shr_word;
    logic [31:0] shl_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // ~addr equals 3-addr for a 2-bit value
    assign shr_word = dm_rdata >> {addr, 3'b000};
    assign shl_word = dm_rdata << {~addr, 3'b000};
    assign byte_sel = shr_word[7:0];
    assign half_sel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        data = dm_rdata;
        be   = 4'b1111;
        case (load_type)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'd0, byte_sel};
            LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: data = {16'd0, half_sel};
            LOAD_LWL: begin
                data = shl_word;
                be   = 4'b1111 << ~addr;
            end
            LOAD_LWR: begin
                data = shr_word;
                be   = 4'b1111 >> addr;
            end
            default:  data = dm_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data with a
// bounded timeout and drives the register-file write port.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   mem,
    input  logic [31:0] dm_rdata,
    input  logic        dm_rvalid,
    output logic [31:0] wbdata,
    output logic [3:0]  reg_we,
    output logic [4:0]  wb_wr,
    output logic        load_timeout
);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    load_ctx_t        ctx_q, ctx_d;
    logic [31:0]      wbdata_q, wbdata_d;
    logic [3:0]       reg_we_q, reg_we_d;
    logic [4:0]       wb_wr_q, wb_wr_d;
    logic             timeout_q, timeout_d;

    logic [31:0]      align_data;
    logic [3:0]       align_be;
    logic             accept;

    load_align u_load_align (
        .dm_rdata  (dm_rdata),
        .addr      (ctx_q.addr),
        .load_type (ctx_q.load_type),
        .data      (align_data),
        .be        (align_be)
    );

    assign mem.mem_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = mem.mem_valid && mem.mem_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctx_d     = ctx_q;
        wbdata_d  = wbdata_q;
        wb_wr_d   = wb_wr_q;
        reg_we_d  = 4'b0000;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mem.mem_sel_wbdata == SEL_WB_LOAD) begin
                        ctx_d = '{wr:        mem.mem_wr,
                                  reg_wen:   mem.mem_reg_wen,
                                  load_type: mem.mem_load_type,
                                  addr:      mem.mem_alu_res[1:0]};
                        cnt_d   = '0;
                        state_d = ST_WAIT_DM;
                    end else if (mem.mem_reg_wen && (mem.mem_wr != 5'd0)) begin
                        wbdata_d = (mem.mem_sel_wbdata == SEL_WB_LINK) ?
                                   (mem.mem_pc + 32'd8) : mem.mem_alu_res;
                        reg_we_d = 4'b1111;
                        wb_wr_d  = mem.mem_wr;
                    end
                end
            end
            ST_WAIT_DM: begin
                // A response on the last allowed cycle still wins over the timeout
                if (dm_rvalid) begin
                    state_d = ST_IDLE;
                    if (ctx_q.reg_wen && (ctx_q.wr != 5'd0)) begin
                        wbdata_d = align_data;
                        reg_we_d = align_be;
                        wb_wr_d  = ctx_q.wr;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctx_q     <= '0;
            wbdata_q  <= 32'd0;
            reg_we_q  <= 4'b0000;
            wb_wr_q   <= 5'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctx_q     <= ctx_d;
            wbdata_q  <= wbdata_d;
            reg_we_q  <= reg_we_d;
            wb_wr_q   <= wb_wr_d;
            timeout_q <= timeout_d;
        end
    end

    assign wbdata       = wbdata_q;
    assign reg_we       = reg_we_q;
    assign wb_wr        = wb_wr_q;
    assign load_timeout = timeout_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases followed by random traffic,
// checked against a byte-level behavioural model of the writeback rules.
module tb_wb_stage;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit          to;
        logic [31:0] data;
        logic [3:0]  we;
        logic [4:0]  wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm_rdata = 32'd0;
    logic        dm_rvalid = 1'b0;
    logic [31:0] wbdata;
    logic [3:0]  reg_we;
    logic [4:0]  wb_wr;
    logic        load_timeout;

    wb_stage_if bus ();

    wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus),
        .dm_rdata     (dm_rdata),
        .dm_rvalid    (dm_rvalid),
        .wbdata       (wbdata),
        .reg_we       (reg_we),
        .wb_wr        (wb_wr),
        .load_timeout (load_timeout)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_data = 32'd0;
    logic [4:0]  last_wr   = 5'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-lane view of the load result
    function automatic exp_t model_load(input logic [2:0] lt, input logic [1:0] a,
                                        input logic [31:0] r, input logic [4:0] wr);
        exp_t e;
        logic [7:0] b[4];
        int ai;
        ai = int'(a);
        for (int i = 0; i < 4; i++) b[i] = r[8*i +: 8];
        e.to = 1'b0;
        e.wr = wr;
        e.we = 4'b1111;
        e.data = r;
        case (lt)
            3'd1: e.data = {{24{b[ai][7]}}, b[ai]};
            3'd2: e.data = {24'd0, b[ai]};
            3'd3: e.data = {{16{b[(ai/2)*2+1][7]}}, b[(ai/2)*2+1], b[(ai/2)*2]};
            3'd4: e.data = {16'd0, b[(ai/2)*2+1], b[(ai/2)*2]};
            3'd5: begin
                e.data = 32'd0;
                e.we = 4'b0000;
                for (int i = 0; i <= ai; i++) begin
                    e.data[8*(3-ai+i) +: 8] = b[i];
                    e.we[3-ai+i] = 1'b1;
                end
            end
            3'd6: begin
                e.data = 32'd0;
                e.we = 4'b0000;
                for (int i = ai; i < 4; i++) begin
                    e.data[8*(i-ai) +: 8] = b[i];
                    e.we[i-ai] = 1'b1;
                end
            end
            default: e.data = r;
        endcase
        return e;
    endfunction

    // Monitor: pops one expectation per write pulse or timeout pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_data = 32'd0;
            last_wr   = 5'd0;
        end else if (load_timeout === 1'b1) begin
            $display("[TB] timeout pulse reg_we=%b", reg_we);
            chk("timeout_reg_we", 32'(reg_we), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_timeout", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("timeout_expected", 32'(e.to), 32'd1);
            end
        end else if (reg_we !== 4'b0000) begin
            $display("[TB] write wr=%0d data=%h we=%b", wb_wr, wbdata, reg_we);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(reg_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_not_timeout", 32'(e.to), 32'd0);
                chk("wb_reg_we", 32'(reg_we), 32'(e.we));
                chk("wb_data", wbdata, e.data);
                chk("wb_wr", 32'(wb_wr), 32'(e.wr));
                last_data = e.data;
                last_wr   = e.wr;
            end
        end else begin
            chk("hold_data", wbdata, last_data);
            chk("hold_wr", 32'(wb_wr), 32'(last_wr));
        end
    end

    task automatic issue_op(input logic [4:0] wr, input logic wen, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc);
        exp_t e;
        bus.mem_valid      = 1'b1;
        bus.mem_wr         = wr;
        bus.mem_reg_wen    = wen;
        bus.mem_sel_wbdata = sel;
        bus.mem_load_type  = 3'($urandom_range(0, 7));
        bus.mem_alu_res    = alu;
        bus.mem_pc         = pc;
        chk("ready_idle", 32'(bus.mem_ready), 32'd1);
        if (wen && wr != 5'd0) begin
            e.to = 1'b0;
            e.data = (sel == 2'd2) ? pc + 32'd8 : alu;
            e.we = 4'b1111;
            e.wr = wr;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        bus.mem_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // d = cycles after accept at which dm_rvalid is seen
    task automatic issue_load(input logic [4:0] wr, input logic wen, input logic [2:0] lt,
                              input logic [31:0] addr, input logic [31:0] r, input int d);
        exp_t e;
        int last;
        bus.mem_valid      = 1'b1;
        bus.mem_wr         = wr;
        bus.mem_reg_wen    = wen;
        bus.mem_sel_wbdata = 2'd1;
        bus.mem_load_type  = lt;
        bus.mem_alu_res    = addr;
        bus.mem_pc         = $urandom;
        chk("ready_idle", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        if (d <= TIMEOUT) begin
            if (wen && wr != 5'd0) begin
                e = model_load(lt, addr[1:0], r, wr);
                exp_q.push_back(e);
            end
        end else begin
            e.to = 1'b1;
            e.data = 32'd0;
            e.we = 4'b0000;
            e.wr = 5'd0;
            exp_q.push_back(e);
        end
        last = (d > TIMEOUT) ? d : d;
        for (int k = 1; k <= last; k++) begin
            if (k <= TIMEOUT)
                chk("ready_wait", 32'(bus.mem_ready), 32'd0);
            else
                chk("ready_after_timeout", 32'(bus.mem_ready), 32'd1);
            dm_rdata  = (k == d) ? r : $urandom;
            dm_rvalid = (k == d);
            tick();
        end
        dm_rvalid = 1'b0;
        chk("ready_after_load", 32'(bus.mem_ready), 32'd1);
    endtask

    initial begin
        bus.mem_valid      = 1'b0;
        bus.mem_wr         = 5'd0;
        bus.mem_reg_wen    = 1'b0;
        bus.mem_sel_wbdata = 2'd0;
        bus.mem_load_type  = 3'd0;
        bus.mem_alu_res    = 32'd0;
        bus.mem_pc         = 32'd0;
        tick();
        tick();
        chk("reset_wbdata", wbdata, 32'd0);
        chk("reset_reg_we", 32'(reg_we), 32'd0);
        chk("reset_wb_wr", 32'(wb_wr), 32'd0);
        chk("reset_timeout", 32'(load_timeout), 32'd0);
        chk("reset_ready", 32'(bus.mem_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.mem_ready), 32'd1);

        // ALU, write to r0, link, back-to-back
        issue_op(5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'd0);
        issue_op(5'd0, 1'b1, 2'd0, 32'h1234_5678, 32'd0);
        issue_op(5'd31, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'hBFC0_0000);
        issue_op(5'd7, 1'b1, 2'd3, 32'h0000_0011, 32'd0);
        idle(1);
        for (int i = 0; i < 4; i++)
            issue_op(5'(i + 1), 1'b1, 2'd0, $urandom, $urandom);
        issue_op(5'd9, 1'b1, 2'd2, 32'd0, 32'hFFFF_FFFC);
        idle(2);

        // Byte loads, partial-word merges
        issue_load(5'd3, 1'b1, 3'd1, 32'h1000_0002, 32'h0080_0000, 3);
        issue_load(5'd4, 1'b1, 3'd2, 32'h1000_0002, 32'h0080_0000, 3);
        issue_load(5'd6, 1'b1, 3'd5, 32'h1000_0001, 32'hAABB_CCDD, 2);
        issue_load(5'd6, 1'b1, 3'd6, 32'h1000_0001, 32'hAABB_CCDD, 1);
        issue_load(5'd8, 1'b1, 3'd3, 32'h1000_0002, 32'h8001_7FFF, 1);
        issue_load(5'd8, 1'b1, 3'd4, 32'h1000_0000, 32'h8001_8002, 2);
        issue_load(5'd2, 1'b0, 3'd0, 32'h1000_0000, 32'h1111_2222, 2);
        idle(1);

        // Timeout with a late response, and the two edges of the window
        issue_load(5'd10, 1'b1, 3'd0, 32'h2000_0000, 32'hCAFE_F00D, 20);
        issue_load(5'd11, 1'b1, 3'd0, 32'h2000_0004, 32'h0BAD_CAFE, TIMEOUT);
        issue_load(5'd12, 1'b1, 3'd0, 32'h2000_0008, 32'h1357_9BDF, TIMEOUT + 1);
        idle(2);

        // Reset in the middle of a load wait
        bus.mem_valid      = 1'b1;
        bus.mem_wr         = 5'd13;
        bus.mem_reg_wen    = 1'b1;
        bus.mem_sel_wbdata = 2'd1;
        bus.mem_load_type  = 3'd0;
        bus.mem_alu_res    = 32'h3000_0000;
        tick();
        bus.mem_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_wbdata", wbdata, 32'd0);
        chk("midreset_reg_we", 32'(reg_we), 32'd0);
        chk("midreset_wb_wr", 32'(wb_wr), 32'd0);
        chk("midreset_timeout", 32'(load_timeout), 32'd0);
        chk("midreset_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_midreset", 32'(bus.mem_ready), 32'd1);
        dm_rdata  = 32'h5555_AAAA;
        dm_rvalid = 1'b1;
        tick();
        dm_rvalid = 1'b0;
        idle(TIMEOUT + 2);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            logic [1:0]  sel;
            logic [4:0]  wr;
            logic        wen;
            int          d;
            sel = 2'($urandom_range(0, 3));
            wr  = 5'($urandom_range(0, 31));
            wen = ($urandom_range(0, 4) != 0);
            if (sel == 2'd1) begin
                d = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 6);
                issue_load(wr, wen, 3'($urandom_range(0, 7)), $urandom, $urandom, d);
            end else begin
                issue_op(wr, wen, sel, $urandom, $urandom);
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
